// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a-b-bin over WIDTH cycles using one full-subtractor stage, LSB first.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, sd;
  logic [WIDTH:0] sd_ext;
  logic [CW-1:0] cnt;
  logic br, d, bo, last;
  assign d = sa[0] ^ sb[0] ^ br;
  assign bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign sd_ext = {d, sd};
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      sd <= '0;
      br <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sa <= a;
          sb <= b;
          sd <= '0;
          br <= bin;
          cnt <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sd <= sd_ext[WIDTH:1];
          br <= bo;
          cnt <= cnt + 1'b1;
          if (last) begin
            diff <= sd_ext[WIDTH:1];
            bout <= bo;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
  // d on the last RUN edge is the result sign bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN && last) begin
      ovf <= (a_msb ^ b_msb) & (a_msb ^ d);
    end
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed and random checks of serial_sub_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_sub_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin_i = 1'b0;
  logic [7:0] a_i = '0, b_i = '0;
  logic busy, done, bout, ovf;
  logic [7:0] diff;
  int n_tests = 0, n_fail = 0;
  logic [7:0] last_diff = '0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i), .bin(bin_i),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns {ovf, bout, diff} from plain integer arithmetic
  function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
    int u, s;
    logic o;
    u = int'(x) - int'(y) - int'(bi);
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
`ifdef SERIAL_SUB_OVF_EN
    o = (s < -128) || (s > 127);
`else
    o = 1'b0;
`endif
    return {o, u < 0, u[7:0]};
  endfunction

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [9:0] e;
    int n;
    e = ref_sub(x, y, bi);
    a_i = x; b_i = y; bin_i = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a_i = $urandom; b_i = $urandom; bin_i = 1'($urandom);
    check("busy_acc", busy, 1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (n == 3) check("hold_diff", diff, last_diff);
    end
    check("latency", n, 8);
    check("diff", diff, e[7:0]);
    check("bout", bout, e[8]);
    check("ovf", ovf, e[9]);
    last_diff = e[7:0];
    tick();
    check("done_pulse", done, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    logic [9:0] e;
    logic prev_busy;
    int dones, acc, n;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();
    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 40; i++) run_op(8'($urandom), 8'($urandom), 1'($urandom));
    // start held high; operands changed mid-run
    a_i = 8'h10; b_i = 8'h01; bin_i = 1'b0; start = 1'b1;
    tick();
    dones = 0; acc = 0; prev_busy = busy;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin a_i = 8'hAA; b_i = 8'h55; end
      tick();
      if (done) begin
        dones++;
        if (dones == 1) check("bp_diff", diff, 8'h0F);
      end
      if (!prev_busy && busy && acc == 0) acc = k;
      prev_busy = busy;
    end
    start = 1'b0;
    check("bp_reaccept", acc, 10);
    check("bp_dones", dones, 1);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    e = ref_sub(8'hAA, 8'h55, 1'b0);
    check("bp2_diff", diff, e[7:0]);
    check("bp2_bout", bout, e[8]);
    check("bp2_ovf", ovf, e[9]);
    last_diff = e[7:0];
    tick();
    check("bp2_pulse", done, 0);
    // asynchronous reset during RUN
    a_i = 8'h90; b_i = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_diff", diff, 0);
    check("ar_bout", bout, 0);
    check("ar_ovf", ovf, 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) rst_n = 1'b1;
      tick();
      if (done) dones++;
    end
    check("ar_nodone", dones, 0);
    check("ar_idle", busy, 0);
    last_diff = '0;
    run_op(8'h20, 8'h20, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
